// File: rtl/pack_from_spi.sv
// Host-side SPI initiator for the trace frame protocol: sends one command word,
// streams the requested 128-bit frames to a valid/ready sink, then reads a status trailer.
module pack_from_spi #(
  parameter int CSSETUP = 4,
  parameter int CSHIGH  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [1:0]   ReqWidth,
  input  logic [15:0]  ReqCount,
  output logic         CSn,
  output logic         XferGo,
  output logic [31:0]  TxWord,
  input  logic         XferDone,
  input  logic [127:0] RxWord,
  output logic [127:0] Frame,
  output logic         FrameValid,
  input  logic         FrameReady,
  output logic [15:0]  FramesAvail,
  output logic         Busy,
  output logic         ProtoErr
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, FRAMES, TRAILER, CS_HOLD} state_t;

  state_t      state, next_state;
  logic [31:0] cmd_word;
  logic [15:0] timer;
  logic [15:0] remaining;
  logic [15:0] rem_after;
  logic        waiting;

  logic        is_header;
  logic        handshake;
  logic        start_ok;
  logic        timer_last;
  logic        frame_load;
  logic        slot_free;
  logic        frames_go;
  logic        go_d;
  logic [31:0] tx_d;

  assign is_header  = (RxWord[127:120] == 8'hA6) && (RxWord[31:0] == 32'hFFFF_FF7F);
  assign handshake  = FrameValid && FrameReady;
  assign start_ok   = (state == IDLE) && Start;
  assign timer_last = (timer <= 16'd1);
  assign frame_load = (state == FRAMES) && waiting && XferDone;
  assign rem_after  = (frame_load && remaining != 16'd0) ? remaining - 16'd1 : remaining;

  // A new exchange may start only if the output slot is free (or freeing now); when the
  // frame is being loaded this very edge, it also needs the sink to be ready already.
  assign slot_free  = (!FrameValid || handshake) && (!frame_load || FrameReady);
  assign frames_go  = (state == FRAMES) && (frame_load || !waiting) && slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (Start) next_state = CS_SETUP;
      CS_SETUP: if (timer_last) next_state = CMD;
      CMD: begin
        if (XferDone) begin
          if (!is_header)                  next_state = CS_HOLD;
          else if (cmd_word[15:0] == 16'd0) next_state = TRAILER;
          else                              next_state = FRAMES;
        end
      end
      FRAMES:   if (frames_go && rem_after == 16'd0) next_state = TRAILER;
      TRAILER:  if (XferDone) next_state = CS_HOLD;
      CS_HOLD:  if (timer_last) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    go_d = 1'b0;
    tx_d = 32'h0;
    case (state)
      CS_SETUP: if (timer_last) begin
        go_d = 1'b1;
        tx_d = cmd_word;
      end
      CMD:      if (XferDone && is_header) go_d = 1'b1;
      FRAMES:   if (frames_go) go_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CSn         <= 1'b1;
      XferGo      <= 1'b0;
      TxWord      <= 32'h0;
      Frame       <= 128'h0;
      FrameValid  <= 1'b0;
      FramesAvail <= 16'h0;
      Busy        <= 1'b0;
      ProtoErr    <= 1'b0;
      cmd_word    <= 32'h0;
      timer       <= 16'h0;
      remaining   <= 16'h0;
      waiting     <= 1'b0;
    end else begin
      XferGo <= go_d;
      if (go_d) TxWord <= tx_d;
      CSn    <= !(next_state inside {CS_SETUP, CMD, FRAMES, TRAILER});
      Busy   <= (next_state != IDLE);

      if (go_d)          waiting <= 1'b1;
      else if (XferDone) waiting <= 1'b0;

      if (start_ok)
        timer <= 16'(CSSETUP);
      else if (next_state == CS_HOLD && state != CS_HOLD)
        timer <= 16'(CSHIGH);
      else if (timer != 16'd0)
        timer <= timer - 16'd1;

      if (start_ok) cmd_word <= {8'h01, 6'h0, ReqWidth, ReqCount};

      if (state == CMD && XferDone && is_header) remaining <= cmd_word[15:0];
      else if (frame_load)                       remaining <= rem_after;

      if (frame_load) Frame <= RxWord;
      if (frame_load)     FrameValid <= 1'b1;
      else if (handshake) FrameValid <= 1'b0;

      if (state == TRAILER && XferDone && is_header) FramesAvail <= RxWord[119:104];

      if (start_ok)
        ProtoErr <= 1'b0;
      else if ((state == CMD || state == TRAILER) && XferDone && !is_header)
        ProtoErr <= 1'b1;
    end
  end

endmodule
